// File: rtl/dsm_interp_feeder.sv
// Purpose: buffers signed PCM samples and drives a linear (first-order-hold) ramp plus clk_en strobe to the DSM DAC.
// Latency: a sample popped at a span boundary is reached exactly by dsm_in one span (2**OSR_LOG2 strobes) later.
// Backpressure: s_ready (registered) drops while the FIFO is full; an empty FIFO at a span boundary holds dsm_in and pulses underrun.
module dsm_interp_feeder #(
    parameter int WIDTH      = 16,
    parameter int CLK_DIV    = 4,
    parameter int OSR_LOG2   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [WIDTH-1:0]              dsm_in,
    output logic                          clk_en,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DW   = $clog2(CLK_DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int ACCW = WIDTH + OSR_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    // strobe divider and span phase
    logic [DW-1:0]       div_q;
    logic [OSR_LOG2-1:0] ph_q;
    logic                clk_en_q;
    logic                tick;
    logic                wrap;

    // input FIFO
    logic [WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wptr_q;
    logic [AW-1:0]       rptr_q;
    logic [LW-1:0]       cnt_q;
    logic [LW-1:0]       cnt_d;
    logic                s_ready_q;
    logic                push;
    logic                pop;
    logic                empty;
    logic [WIDTH-1:0]    head;

    // interpolator
    state_t              state_q;
    logic [WIDTH-1:0]    cur_q;
    logic [WIDTH:0]      delta_q;
    logic [ACCW-1:0]     acc_q;
    logic                underrun_q;
    logic [ACCW-1:0]     cur_scaled;
    logic [ACCW-1:0]     delta_ext;

    assign tick  = (div_q == DW'(CLK_DIV - 1));
    assign wrap  = tick && (ph_q == {OSR_LOG2{1'b1}});

    assign empty = (cnt_q == '0);
    assign push  = s_valid && s_ready_q;
    // pop decision uses pre-push occupancy, so a same-cycle push is never fall-through
    assign pop   = wrap && !empty;
    assign head  = mem_q[rptr_q];

    // cur scaled to accumulator precision, and delta sign-extended to it
    assign cur_scaled = {cur_q[WIDTH-1], cur_q, {OSR_LOG2{1'b0}}};
    assign delta_ext  = {{OSR_LOG2{delta_q[WIDTH]}}, delta_q};

    // Divider counts 0..CLK_DIV-1; clk_en is the registered tick, phase advances per tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            ph_q     <= '0;
            clk_en_q <= 1'b0;
        end else begin
            clk_en_q <= tick;
            if (tick) begin
                div_q <= '0;
                ph_q  <= ph_q + OSR_LOG2'(1);
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    // Next FIFO occupancy: simultaneous push and pop leave the level unchanged
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointers, level and registered not-full flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q     <= cnt_d;
            s_ready_q <= (cnt_d != LW'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= s_data;
    end

    // Interpolator FSM: restart each span at cur, ramp by delta per strobe toward head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            delta_q    <= '0;
            acc_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (wrap) begin
                acc_q <= cur_scaled;
                if (!empty) begin
                    delta_q <= {head[WIDTH-1], head} - {cur_q[WIDTH-1], cur_q};
                    cur_q   <= head;
                    state_q <= RUN;
                end else begin
                    delta_q <= '0;
                    if (state_q != IDLE) begin
                        state_q    <= HOLD;
                        underrun_q <= 1'b1;
                    end
                end
            end else if (tick) begin
                acc_q <= acc_q + delta_ext;
            end
        end
    end

    // floor(acc / 2**OSR_LOG2), truncated to the DAC width
    assign dsm_in     = acc_q[OSR_LOG2 +: WIDTH];
    assign clk_en     = clk_en_q;
    assign underrun   = underrun_q;
    assign fifo_level = cnt_q;
    assign s_ready    = s_ready_q;

endmodule

// File: tb/tb_dsm_interp_feeder.sv
// Purpose: randomized and directed stimulus for dsm_interp_feeder, checked every cycle against a span-level interpolation model.
// Latency: model predicts post-edge outputs; compare runs on the falling edge.
// Backpressure: model tracks FIFO occupancy and predicts s_ready; pushes are taken only when ready.
module tb_dsm_interp_feeder;

    localparam int WIDTH      = 16;
    localparam int CLK_DIV    = 2;
    localparam int OSR_LOG2   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int SPAN       = 1 << OSR_LOG2;

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic [WIDTH-1:0]  s_data  = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [WIDTH-1:0]  dsm_in;
    logic              clk_en;
    logic              underrun;
    logic [2:0]        fifo_level;

    dsm_interp_feeder #(
        .WIDTH      (WIDTH),
        .CLK_DIV    (CLK_DIV),
        .OSR_LOG2   (OSR_LOG2),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .dsm_in     (dsm_in),
        .clk_en     (clk_en),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // behavioural model: sample queue plus current segment endpoints
    int n_edges;
    int q[$];
    int seg_start;
    int seg_end;
    bit started;
    bit m_ready;
    int exp_dsm;
    bit exp_clk_en;
    bit exp_under;
    int exp_level;
    bit chk_on = 1'b0;

    logic [WIDTH-1:0] strobe_log[$];
    int n_under;
    int n_strobe;

    function automatic int floor_div(int a, int b);
        int qt = a / b;
        if ((a % b != 0) && (a < 0)) qt = qt - 1;
        return qt;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    task automatic check_log(input string name, input int idx, input int req);
        if (idx < strobe_log.size()) begin
            check(name, int'(strobe_log[idx]), req);
        end else begin
            vectors++;
            errors++;
            $display("FAIL %s: only %0d strobes logged, needed index %0d", name, strobe_log.size(), idx);
        end
    endtask

    task automatic model_reset();
        n_edges    = 0;
        q.delete();
        seg_start  = 0;
        seg_end    = 0;
        started    = 1'b0;
        m_ready    = 1'b0;
        exp_dsm    = 0;
        exp_clk_en = 1'b0;
        exp_under  = 1'b0;
        exp_level  = 0;
    endtask

    // One rising edge: strobe every CLK_DIV edges, span boundary every SPAN strobes,
    // and dsm_in = start + floor(k*(end-start)/SPAN) for strobe k within the span.
    task automatic model_step(input bit v, input logic [WIDTH-1:0] d);
        bit push;
        int lvl;
        int t;
        int k;
        push      = v && m_ready;
        lvl       = q.size();
        n_edges++;
        exp_under = 1'b0;
        exp_clk_en = ((n_edges % CLK_DIV) == 0);
        if (exp_clk_en) begin
            t = n_edges / CLK_DIV;
            k = t % SPAN;
            if (k == 0) begin
                seg_start = seg_end;
                if (lvl > 0) begin
                    seg_end = q.pop_front();
                    started = 1'b1;
                end else if (started) begin
                    exp_under = 1'b1;
                end
            end
            exp_dsm = seg_start + floor_div(k * (seg_end - seg_start), SPAN);
        end
        if (push) q.push_back(int'($signed(d)));
        m_ready   = (q.size() < FIFO_DEPTH);
        exp_level = q.size();
    endtask

    // single compare process, every falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("dsm_in",     int'($signed(dsm_in)), exp_dsm);
            check("clk_en",     int'(clk_en),          int'(exp_clk_en));
            check("underrun",   int'(underrun),        int'(exp_under));
            check("fifo_level", int'(fifo_level),      exp_level);
            check("s_ready",    int'(s_ready),         int'(m_ready));
            if (clk_en) begin
                strobe_log.push_back(dsm_in);
                n_strobe++;
            end
            if (underrun) n_under++;
        end
    end

    task automatic step(input bit v, input logic [WIDTH-1:0] d);
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        model_step(v, d);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        s_valid = 1'b0;
        model_reset();
        strobe_log.delete();
        n_under  = 0;
        n_strobe = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        n_under  = 0;
        n_strobe = 0;
        chk_on   = 1'b1;

        // idle after reset: strobe keeps running, no underrun, output stays 0
        do_reset();
        repeat (40) step(1'b0, '0);
        check("t1_underrun_count", n_under, 0);
        check("t1_strobe_count",   n_strobe, 20);

        // 0x0100 ramp from 0
        do_reset();
        step(1'b0, '0);
        repeat (4) step(1'b1, 16'h0100);
        repeat (15) step(1'b0, '0);
        check_log("t2_s3", 3, 'h0000);
        check_log("t2_s4", 4, 'h0040);
        check_log("t2_s5", 5, 'h0080);
        check_log("t2_s6", 6, 'h00C0);
        check_log("t2_s7", 7, 'h0100);
        check_log("t2_s8", 8, 'h0100);

        // floor of negatives: 0 -> -1
        do_reset();
        step(1'b0, '0);
        step(1'b1, 16'hFFFF);
        repeat (18) step(1'b0, '0);
        check_log("t3_s3", 3, 'h0000);
        check_log("t3_s4", 4, 'hFFFF);
        check_log("t3_s5", 5, 'hFFFF);
        check_log("t3_s7", 7, 'hFFFF);
        check("t3_underrun_count", n_under, 1);

        // full-scale step 0x8000 -> 0x7FFF, monotonic, no wrap-around
        do_reset();
        step(1'b0, '0);
        step(1'b1, 16'h8000);
        step(1'b1, 16'h7FFF);
        repeat (23) step(1'b0, '0);
        check_log("t4_s7",  7,  'h8000);
        check_log("t4_s8",  8,  'hBFFF);
        check_log("t4_s9",  9,  'hFFFF);
        check_log("t4_s10", 10, 'h3FFF);
        check_log("t4_s11", 11, 'h7FFF);
        if (strobe_log.size() > 11) begin
            for (int i = 8; i <= 11; i++)
                check("t4_monotonic", int'($signed(strobe_log[i]) > $signed(strobe_log[i-1])), 1);
        end else begin
            vectors++;
            errors++;
            $display("FAIL t4_monotonic: only %0d strobes logged", strobe_log.size());
        end

        // fill FIFO; 5th sample refused; one pop at the boundary frees a slot
        do_reset();
        step(1'b0, '0);
        step(1'b1, 16'h1111);
        step(1'b1, 16'h2222);
        step(1'b1, 16'h3333);
        step(1'b1, 16'h4444);
        check("t5_level_full", int'(fifo_level), 4);
        check("t5_ready_full", int'(s_ready), 0);
        step(1'b1, 16'h5555);
        step(1'b1, 16'h5555);
        check("t5_level_refused", int'(fifo_level), 4);
        step(1'b1, 16'h5555);
        check("t5_level_after_wrap", int'(fifo_level), 3);
        check("t5_ready_after_wrap", int'(s_ready), 1);
        repeat (4) step(1'b0, '0);

        // starvation, resume, then async reset mid-span
        do_reset();
        step(1'b0, '0);
        step(1'b1, 16'h0123);
        repeat (38) step(1'b0, '0);
        check("t6_underrun_count", n_under, 4);
        check("t6_hold_value", int'(dsm_in), 'h0123);
        step(1'b1, 16'h0200);
        step(1'b1, 16'h0200);
        repeat (10) step(1'b0, '0);
        s_valid = 1'b0;
        @(posedge clk);
        model_step(1'b0, '0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_rst_dsm_in",     int'(dsm_in),     0);
        check("t6_rst_clk_en",     int'(clk_en),     0);
        check("t6_rst_underrun",   int'(underrun),   0);
        check("t6_rst_fifo_level", int'(fifo_level), 0);
        check("t6_rst_s_ready",    int'(s_ready),    0);
        do_reset();

        // randomized traffic at several input rates
        for (int blk = 0; blk < 8; blk++) begin
            int p;
            p = 5 + blk * 12;
            do_reset();
            repeat (300) step(int'($urandom_range(99)) < p, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
